mem_arbiter: RTL and testbench

//  Arbitrates the single shared multicycle main memory between the instruction cache
//  (I port) and the data cache (D port). It replaces the fixed priority used for I and

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one multicycle memory between the I and D caches. An ownership FSM holds the
// grant for a whole burst and until that owner's outstanding reads have all returned.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_ren,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              i_gnt,
   output logic              i_stall,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_data_valid,
   input  logic              d_req,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_stall,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_data_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ren,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_valid,
   output logic              protocol_err,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_I_BUSY  = 3'd1,
      S_I_DRAIN = 3'd2,
      S_D_BUSY  = 3'd3,
      S_D_DRAIN = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_last_i, w_last_i_nxt;
   logic              r_err;

   logic              w_i_own, w_d_own, w_busy;
   logic              w_own_ren, w_own_wen;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;
   logic              w_rd_try, w_ovf, w_fwd_ren, w_cnt_zero, w_ret, w_err_set;

   assign w_i_own = (r_state == S_I_BUSY) || (r_state == S_I_DRAIN);
   assign w_d_own = (r_state == S_D_BUSY) || (r_state == S_D_DRAIN);
   assign w_busy  = (r_state == S_I_BUSY) || (r_state == S_D_BUSY);

   assign w_own_ren   = w_i_own ? i_ren   : d_ren;
   assign w_own_wen   = w_i_own ? i_wen   : d_wen;
   assign w_own_addr  = w_i_own ? i_addr  : d_addr;
   assign w_own_wdata = w_i_own ? i_wdata : d_wdata;

   // A write wins over a simultaneous read; a read beyond MAX_OUT in flight is refused
   // unless a return frees a slot in the same cycle.
   assign w_rd_try   = w_busy & w_own_ren & ~w_own_wen;
   assign w_ovf      = w_rd_try & (r_cnt == CNT_W'(MAX_OUT)) & ~mem_data_valid;
   assign w_fwd_ren  = w_rd_try & ~w_ovf;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_ret      = mem_data_valid & ~w_cnt_zero;
   assign w_err_set  = w_ovf | (w_busy & w_own_ren & w_own_wen) | (mem_data_valid & w_cnt_zero);

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_fwd_ren && !w_ret)
         w_cnt_nxt = r_cnt + CNT_W'(1);
      else if (!w_fwd_ren && w_ret)
         w_cnt_nxt = r_cnt - CNT_W'(1);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_last_i_nxt = r_last_i;
      case (r_state)
         S_IDLE: begin
            if (i_req && (!d_req || !r_last_i)) begin
               w_state_nxt  = S_I_BUSY;
               w_last_i_nxt = 1'b1;
            end else if (d_req) begin
               w_state_nxt  = S_D_BUSY;
               w_last_i_nxt = 1'b0;
            end
         end
         S_I_BUSY:
            if (!i_req) w_state_nxt = (w_cnt_nxt != '0) ? S_I_DRAIN : S_IDLE;
         S_I_DRAIN:
            if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
         S_D_BUSY:
            if (!d_req) w_state_nxt = (w_cnt_nxt != '0) ? S_D_DRAIN : S_IDLE;
         S_D_DRAIN:
            if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_last_i <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_last_i <= w_last_i_nxt;
         r_err    <= r_err | w_err_set;
      end
   end

   assign i_gnt        = w_i_own;
   assign d_gnt        = w_d_own;
   assign i_stall      = (i_req & ~w_i_own) | (w_i_own & w_ovf);
   assign d_stall      = (d_req & ~w_d_own) | (w_d_own & w_ovf);
   assign i_data_valid = w_i_own & w_ret;
   assign d_data_valid = w_d_own & w_ret;
   assign i_rdata      = i_data_valid ? mem_rdata : '0;
   assign d_rdata      = d_data_valid ? mem_rdata : '0;

   assign mem_ren      = w_fwd_ren;
   assign mem_wen      = w_busy & w_own_wen;
   assign mem_addr     = w_busy ? w_own_addr  : '0;
   assign mem_wdata    = w_busy ? w_own_wdata : '0;

   assign protocol_err = r_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic against an ownership-level reference model with an in-order memory.
module tb_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MAX_OUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, i_ren, i_wen, d_req, d_ren, d_wen;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] i_wdata, d_wdata;
   logic          i_gnt, i_stall, i_data_valid, d_gnt, d_stall, d_data_valid;
   logic [DW-1:0] i_rdata, d_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ren, mem_wen, mem_data_valid, protocol_err;
   logic [2:0]    dbg_state;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MAX_OUT), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_gnt(i_gnt), .i_stall(i_stall), .i_rdata(i_rdata), .i_data_valid(i_data_valid),
      .d_req(d_req), .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_stall(d_stall), .d_rdata(d_rdata), .d_data_valid(d_data_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
      .protocol_err(protocol_err), .dbg_state(dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // memory: in-order returns scheduled on a ring indexed by cycle
   logic          ret_v [0:255];
   logic [DW-1:0] ret_d [0:255];
   int            last_ret = 0;
   int            lat_max  = 4;
   int            spur_pct = 0;
   logic          inject   = 1'b0;

   // reference model: owner 0=none 1=I 2=D, drain = owner released, waiting for returns
   int   m_owner = 0;
   logic m_drain = 1'b0;
   int   m_out   = 0;
   int   m_last  = 2;
   logic m_err   = 1'b0;

   logic [DW-1:0] exp_q[$];

   logic          obs_i_gnt, obs_i_stall, obs_i_dv, obs_d_gnt, obs_d_stall, obs_d_dv;
   logic          obs_mren, obs_mwen, obs_err;
   logic [AW-1:0] obs_maddr;
   logic [DW-1:0] obs_mwdata;

   int i_left = 0;
   int d_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_check();
      logic          busy, o_ren, o_wen, o_req, rd, ovf, e_mren, ret;
      logic [AW-1:0] o_addr;
      logic [DW-1:0] o_wd;
      busy   = (m_owner != 0) && !m_drain;
      o_req  = (m_owner == 2) ? d_req   : i_req;
      o_ren  = (m_owner == 2) ? d_ren   : i_ren;
      o_wen  = (m_owner == 2) ? d_wen   : i_wen;
      o_addr = (m_owner == 2) ? d_addr  : i_addr;
      o_wd   = (m_owner == 2) ? d_wdata : i_wdata;
      rd     = busy && o_ren && !o_wen;
      ovf    = rd && (m_out == MAX_OUT) && !mem_data_valid;
      e_mren = rd && !ovf;
      ret    = mem_data_valid && (m_out > 0);

      chk("i_gnt", i_gnt, m_owner == 1);
      chk("d_gnt", d_gnt, m_owner == 2);
      chk("i_stall", i_stall, (i_req && m_owner != 1) || (m_owner == 1 && ovf));
      chk("d_stall", d_stall, (d_req && m_owner != 2) || (m_owner == 2 && ovf));
      chk("i_dv", i_data_valid, m_owner == 1 && ret);
      chk("d_dv", d_data_valid, m_owner == 2 && ret);
      chk("i_rdata", i_rdata, (m_owner == 1 && ret) ? mem_rdata : 16'h0);
      chk("d_rdata", d_rdata, (m_owner == 2 && ret) ? mem_rdata : 16'h0);
      chk("mem_ren", mem_ren, e_mren);
      chk("mem_wen", mem_wen, busy && o_wen);
      chk("mem_addr", mem_addr, busy ? o_addr : 16'h0);
      chk("mem_wdata", mem_wdata, busy ? o_wd : 16'h0);
      chk("perr", protocol_err, m_err);
      if (i_data_valid && exp_q.size() > 0) chk("i_rdata_sb", i_rdata, exp_q.pop_front());

      obs_i_gnt = i_gnt; obs_i_stall = i_stall; obs_i_dv = i_data_valid;
      obs_d_gnt = d_gnt; obs_d_stall = d_stall; obs_d_dv = d_data_valid;
      obs_mren = mem_ren; obs_mwen = mem_wen; obs_err = protocol_err;
      obs_maddr = mem_addr; obs_mwdata = mem_wdata;

      if (rst) begin
         m_owner = 0; m_drain = 1'b0; m_out = 0; m_last = 2; m_err = 1'b0;
      end else begin
         if (ovf || (busy && o_ren && o_wen) || (mem_data_valid && m_out == 0)) m_err = 1'b1;
         m_out = m_out + (e_mren ? 1 : 0) - (ret ? 1 : 0);
         if (m_owner == 0) begin
            if (i_req && d_req) m_owner = (m_last == 1) ? 2 : 1;
            else if (i_req)     m_owner = 1;
            else if (d_req)     m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
         end else if (!m_drain) begin
            if (!o_req) begin
               if (m_out > 0) m_drain = 1'b1;
               else m_owner = 0;
            end
         end else if (m_out == 0) begin
            m_owner = 0;
            m_drain = 1'b0;
         end
      end
   endtask

   task automatic step();
      int s;
      s = cyc % 256;
      if (ret_v[s]) begin
         mem_data_valid = 1'b1; mem_rdata = ret_d[s]; ret_v[s] = 1'b0;
      end else if (inject || ($urandom_range(0, 99) < spur_pct)) begin
         mem_data_valid = 1'b1; mem_rdata = 16'($urandom);
      end else begin
         mem_data_valid = 1'b0; mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      model_check();
      if (mem_ren) begin
         int t;
         t = cyc + $urandom_range(4, lat_max);
         if (t <= last_ret) t = last_ret + 1;
         last_ret = t;
         ret_v[t % 256] = 1'b1;
         ret_d[t % 256] = mem_addr ^ 16'h5A5A;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet();
      i_req = 0; i_ren = 0; i_wen = 0; i_addr = '0; i_wdata = '0;
      d_req = 0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic do_reset();
      quiet();
      for (int k = 0; k < 10; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic rand_drive();
      int r;
      if (!i_req) begin
         if ($urandom_range(0, 99) < 20) begin i_req = 1; i_left = $urandom_range(1, 12); end
      end else if (i_left == 0) i_req = 0;
      else i_left--;
      if (!d_req) begin
         if ($urandom_range(0, 99) < 20) begin d_req = 1; d_left = $urandom_range(1, 12); end
      end else if (d_left == 0) d_req = 0;
      else d_left--;
      r = $urandom_range(0, 99);
      i_ren = (r < 65) || (r >= 97);
      i_wen = (r >= 65 && r < 82) || (r >= 97);
      r = $urandom_range(0, 99);
      d_ren = (r < 55) || (r >= 97);
      d_wen = (r >= 55 && r < 80) || (r >= 97);
      i_addr = 16'($urandom); i_wdata = 16'($urandom);
      d_addr = 16'($urandom); d_wdata = 16'($urandom);
      rst = ($urandom_range(0, 999) < 3);
   endtask

   initial begin
      for (int k = 0; k < 256; k++) begin ret_v[k] = 1'b0; ret_d[k] = '0; end
      rst = 1'b1;
      quiet();
      mem_data_valid = 1'b0;
      mem_rdata = '0;
      @(posedge clk);
      #1;
      do_reset();
      chk("reset_gnt", {obs_i_gnt, obs_d_gnt, obs_mren, obs_mwen, obs_err}, 0);

      // 1: eight back-to-back I reads, latency 4
      for (int k = 1; k <= 15; k++) begin
         i_req = (k <= 9);
         i_ren = (k >= 2 && k <= 9);
         i_addr = (k >= 2 && k <= 9) ? 16'h0040 + 16'(2 * (k - 2)) : 16'h0;
         if (k >= 2 && k <= 9) exp_q.push_back(i_addr ^ 16'h5A5A);
         step();
         chk("t1_i_gnt", obs_i_gnt, (k >= 2 && k <= 13));
         chk("t1_i_dv", obs_i_dv, (k >= 6 && k <= 13));
         if (k == 2) chk("t1_addr_first", obs_maddr, 16'h0040);
         if (k == 9) chk("t1_addr_last", obs_maddr, 16'h004E);
      end
      chk("t1_sb_empty", exp_q.size(), 0);

      // 2: simultaneous requests after reset, I first
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         i_req = (k <= 3);
         i_ren = (k == 2 || k == 3);
         i_addr = 16'(k);
         d_req = 1;
         step();
         chk("t2_i_gnt", obs_i_gnt, (k >= 2 && k <= 7));
         chk("t2_d_stall", obs_d_stall, (k <= 8));
         chk("t2_d_gnt", obs_d_gnt, (k >= 9));
      end

      // 3: single D write with req dropped in the same cycle
      do_reset();
      d_req = 1;
      step();
      d_req = 0; d_wen = 1; d_addr = 16'h1000; d_wdata = 16'hBEEF;
      step();
      chk("t3_d_gnt", obs_d_gnt, 1);
      chk("t3_mem_wen", obs_mwen, 1);
      chk("t3_mem_addr", obs_maddr, 16'h1000);
      chk("t3_mem_wdata", obs_mwdata, 16'hBEEF);
      quiet();
      step();
      chk("t3_idle_gnt", obs_d_gnt, 0);
      chk("t3_idle_wen", obs_mwen, 0);

      // 4: I releases with three reads in flight while D waits
      do_reset();
      for (int k = 1; k <= 11; k++) begin
         i_req = (k <= 4);
         i_ren = (k >= 2 && k <= 4);
         d_req = (k >= 5);
         d_ren = (k >= 5);
         d_addr = 16'h0007;
         step();
         if (k >= 5 && k <= 9) chk("t4_mem_ren", obs_mren, 0);
         chk("t4_i_dv", obs_i_dv, (k >= 6 && k <= 8));
         chk("t4_d_gnt", obs_d_gnt, (k >= 10));
      end

      // 5: return with nothing outstanding
      do_reset();
      inject = 1'b1;
      step();
      inject = 1'b0;
      chk("t5_dv", {obs_i_dv, obs_d_dv}, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t5_err_sticky", obs_err, 1);
      end
      do_reset();
      chk("t5_err_cleared", obs_err, 0);

      // 6: reset mid-fill with two reads in flight
      for (int k = 1; k <= 8; k++) begin
         i_req = (k <= 3);
         i_ren = (k == 2 || k == 3);
         rst = (k == 4);
         step();
         if (k == 5) chk("t6_after_rst", {obs_i_gnt, obs_i_stall, obs_mren, obs_err}, 0);
         if (k == 6 || k == 7) chk("t6_late_dv", obs_i_dv, 0);
         if (k >= 7) chk("t6_err", obs_err, 1);
      end
      rst = 1'b0;

      // random traffic with variable latency, stray returns and stray resets
      do_reset();
      lat_max = 6;
      spur_pct = 1;
      for (int k = 0; k < 3000; k++) begin
         rand_drive();
         step();
      end
      rst = 1'b0;
      spur_pct = 0;
      quiet();
      for (int k = 0; k < 12; k++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
